// File: rtl/classifier_driver.sv
// Request-side front end for the packet classifier: buffers headers, issues them one at a
// time over the valid/ready_to_process handshake and returns rule/timeout results downstream.
module classifier_driver #(
  parameter int PKT_W          = 104,
  parameter int RULE_W         = 160,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PKT_W-1:0]  in_packet,
  input  logic              cls_ready,
  output logic              cls_valid,
  output logic [PKT_W-1:0]  cls_packet,
  input  logic [RULE_W-1:0] cls_rule,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  out_packet,
  output logic [RULE_W-1:0] out_rule,
  output logic              out_timeout,
  output logic [15:0]       out_seq,
  output logic              busy,
  output logic [15:0]       timeout_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t            state;
  logic [PKT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [PKT_W-1:0]  hold_pkt;
  logic [TW-1:0]     timer;
  logic              full;
  logic              push;
  logic              pop;

  assign full     = (count == FIFO_FULL);
  assign push     = in_valid && !full;
  assign pop      = (state == ISSUE);
  assign in_ready = !full;
  assign busy     = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_packet;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cls_valid     <= 1'b0;
      cls_packet    <= '0;
      hold_pkt      <= '0;
      timer         <= '0;
      out_valid     <= 1'b0;
      out_packet    <= '0;
      out_rule      <= '0;
      out_timeout   <= 1'b0;
      out_seq       <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0 && cls_ready) begin
            state      <= ISSUE;
            cls_valid  <= 1'b1;
            cls_packet <= mem[rd_ptr];
          end
        end
        ISSUE: begin
          cls_valid <= 1'b0;
          hold_pkt  <= cls_packet;
          timer     <= '0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          timer <= timer + 1'b1;
          if (timer == TIMER_LAST) begin
            out_rule    <= '0;
            out_timeout <= 1'b1;
            out_packet  <= hold_pkt;
            out_valid   <= 1'b1;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
            state       <= RESP;
          end else if (!cls_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          timer <= timer + 1'b1;
          // completion takes priority over a timeout landing in the same cycle
          if (cls_ready) begin
            out_rule    <= cls_rule;
            out_timeout <= 1'b0;
            out_packet  <= hold_pkt;
            out_valid   <= 1'b1;
            state       <= RESP;
          end else if (timer == TIMER_LAST) begin
            out_rule    <= '0;
            out_timeout <= 1'b1;
            out_packet  <= hold_pkt;
            out_valid   <= 1'b1;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_seq   <= out_seq + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_classifier_driver.sv
// Scoreboard bench for classifier_driver with a behavioural classifier model.
module tb_classifier_driver;

  localparam int PKT_W  = 104;
  localparam int RULE_W = 160;
  localparam int DEPTH  = 4;
  localparam int TC     = 16;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [PKT_W-1:0]  in_packet;
  logic              cls_ready;
  logic              cls_valid;
  logic [PKT_W-1:0]  cls_packet;
  logic [RULE_W-1:0] cls_rule;
  logic              out_valid;
  logic              out_ready;
  logic [PKT_W-1:0]  out_packet;
  logic [RULE_W-1:0] out_rule;
  logic              out_timeout;
  logic [15:0]       out_seq;
  logic              busy;
  logic [15:0]       timeout_count;

  classifier_driver #(
    .PKT_W(PKT_W), .RULE_W(RULE_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
    .cls_ready(cls_ready), .cls_valid(cls_valid), .cls_packet(cls_packet), .cls_rule(cls_rule),
    .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet), .out_rule(out_rule),
    .out_timeout(out_timeout), .out_seq(out_seq), .busy(busy), .timeout_count(timeout_count)
  );

  typedef struct {
    logic [PKT_W-1:0]  pkt;
    logic [RULE_W-1:0] rule;
    logic              to;
  } exp_t;

  exp_t              sb[$];
  logic [RULE_W-1:0] rule_q[$];
  exp_t              e_mon;
  logic [15:0]       exp_seq = '0;
  int                n_checks = 0;
  int                n_fail = 0;
  int                cyc = 0;
  int                issue_cnt = 0;
  int                last_issue_cyc = 0;
  int                out_cnt = 0;
  int                last_out_cyc = 0;
  bit                force_low = 0;
  bit                hang = 0;
  int                busy_len = 5;
  logic              model_ready;

  assign cls_ready = model_ready && !force_low;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PKT_W-1:0] mk_pkt(input int i);
    return {32'h0A000000 + 32'(i), 32'hC0A80000 + 32'(i), 16'(1000 + i), 16'(80 + i), 8'(6 + i)};
  endfunction

  function automatic logic [RULE_W-1:0] mk_rule(input int i);
    return {8'(i + 1), 120'h0, 32'hC0DE0000 + 32'(i)};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [PKT_W-1:0] p, input logic [RULE_W-1:0] r,
                               input logic t);
    exp_t e;
    e.pkt = p; e.rule = r; e.to = t;
    sb.push_back(e);
  endtask

  // Classifier model: ready drops the cycle after the pulse, stays low busy_len cycles.
  initial begin
    model_ready = 1'b1;
    cls_rule    = '0;
    forever begin
      @(negedge clk);
      if (cls_valid && !hang) begin
        @(posedge clk);
        #1 model_ready = 1'b0;
        repeat (busy_len) @(posedge clk);
        #1;
        cls_rule    = (rule_q.size() > 0) ? rule_q.pop_front() : '0;
        model_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && cls_valid) begin
      issue_cnt++;
      last_issue_cyc = cyc;
    end
  end

  // Monitor: compares each presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got packet %0h with no result expected", out_packet);
        if (out_ready) begin
          out_cnt++;
          exp_seq++;
        end
      end else begin
        e_mon = sb[0];
        check("out_packet", 256'(out_packet), 256'(e_mon.pkt));
        check("out_rule", 256'(out_rule), 256'(e_mon.rule));
        check("out_timeout", 256'(out_timeout), 256'(e_mon.to));
        check("out_seq", 256'(out_seq), 256'(exp_seq));
        if (out_ready) begin
          void'(sb.pop_front());
          exp_seq++;
          out_cnt++;
          last_out_cyc = cyc;
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_cls_valid", 256'(cls_valid), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_timeout", 256'(out_timeout), 256'(0));
    check("rst_out_rule", 256'(out_rule), 256'(0));
    check("rst_out_packet", 256'(out_packet), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_out_seq", 256'(out_seq), 256'(0));
    check("rst_timeout_count", 256'(timeout_count), 256'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rule_q.delete();
    exp_seq = '0;
    check_reset_vals();
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [PKT_W-1:0] p, output bit acc);
    in_valid  = 1'b1;
    in_packet = p;
    acc       = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while (sb.size() > 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 256'(sb.size()), 256'(0));
  endtask

  initial begin
    int acc_cyc;
    int i0;
    int n_acc;
    int n;
    bit acc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_packet = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single packet, latency and rule capture
    busy_len = 5;
    i0 = issue_cnt;
    rule_q.push_back(160'hAB);
    expect_result(mk_pkt(1), 160'hAB, 1'b0);
    acc_cyc = cyc;
    push_one(mk_pkt(1), acc);
    check("t1_accept", 256'(acc), 256'(1));
    wait_drain("t1", 60);
    check("t1_issue_count", 256'(issue_cnt - i0), 256'(1));
    check("t1_issue_cycle", 256'(last_issue_cyc - acc_cyc), 256'(2));
    check("t1_out_cycle", 256'(last_out_cyc - acc_cyc), 256'(9));

    do_reset();

    // FIFO fill with classifier not ready
    force_low = 1'b1;
    i0 = issue_cnt;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      rule_q.push_back(mk_rule(10 + i));
      expect_result(mk_pkt(10 + i), mk_rule(10 + i), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_packet = mk_pkt(10 + i);
      if (in_ready) n_acc++;
      @(posedge clk);
      #1;
      check("t2_in_ready", 256'(in_ready), 256'((i < 3) ? 1 : 0));
    end
    in_valid = 1'b0;
    check("t2_accepted", 256'(n_acc), 256'(4));
    check("t2_no_issue", 256'(issue_cnt - i0), 256'(0));
    check("t2_busy", 256'(busy), 256'(1));

    // release: four results in order
    busy_len  = 3;
    force_low = 1'b0;
    wait_drain("t3", 200);
    check("t3_issue_count", 256'(issue_cnt - i0), 256'(4));

    // hung classifier forces a timeout
    hang = 1'b1;
    expect_result(mk_pkt(20), '0, 1'b1);
    push_one(mk_pkt(20), acc);
    wait_drain("t4", 80);
    check("t4_timeout_count", 256'(timeout_count), 256'(1));
    hang = 1'b0;
    rule_q.push_back(mk_rule(21));
    expect_result(mk_pkt(21), mk_rule(21), 1'b0);
    push_one(mk_pkt(21), acc);
    wait_drain("t4b", 80);
    check("t4b_timeout_count", 256'(timeout_count), 256'(1));

    // downstream backpressure
    out_ready = 1'b0;
    rule_q.push_back(mk_rule(30));
    rule_q.push_back(mk_rule(31));
    expect_result(mk_pkt(30), mk_rule(30), 1'b0);
    expect_result(mk_pkt(31), mk_rule(31), 1'b0);
    push_one(mk_pkt(30), acc);
    push_one(mk_pkt(31), acc);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_out_valid_seen", 256'(out_valid), 256'(1));
    i0 = issue_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_issue_stalled", 256'(issue_cnt - i0), 256'(0));
    check("t5_seq_held", 256'(out_seq), 256'(exp_seq));
    out_ready = 1'b1;
    wait_drain("t5", 100);

    // reset while waiting for completion
    busy_len = 12;
    rule_q.push_back(mk_rule(40));
    push_one(mk_pkt(40), acc);
    n = 0;
    while (cls_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_cls_busy", 256'(cls_ready), 256'(0));
    repeat (3) @(posedge clk);
    #1;
    i0 = out_cnt;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_late_result", 256'(out_cnt - i0), 256'(0));
    check("t6_idle", 256'(busy), 256'(0));

    busy_len = 3;
    rule_q.push_back(mk_rule(41));
    expect_result(mk_pkt(41), mk_rule(41), 1'b0);
    push_one(mk_pkt(41), acc);
    wait_drain("t6b", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
